// File: rtl/axi4_lite_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_bank_pkg
// Brief    : Shared types and helpers for the AXI4-Lite register bank.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_lite_reg_bank_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = 4;

    // Word index of a byte address; the two byte-offset bits are discarded.
    function automatic logic [31:0] reg_idx(input logic [31:0] byte_addr);
        return byte_addr >> 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_bank_if
// Brief    : AXI4-Lite bus bundle with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_reg_bank_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  AWVALID;
    logic                  AWREADY;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  WVALID;
    logic                  WREADY;
    logic [31:0]           WDATA;
    logic [3:0]            WSTRB;
    logic                  BVALID;
    logic                  BREADY;
    logic [1:0]            BRESP;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  RVALID;
    logic                  RREADY;
    logic [31:0]           RDATA;
    logic [1:0]            RRESP;

    modport master (
        output AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );

    modport slave (
        input  AWVALID, AWADDR, WVALID, WDATA, WSTRB, BREADY, ARVALID, ARADDR, RREADY,
        output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
    );
endinterface
`default_nettype wire

// File: rtl/axil_hold_reg.sv
`default_nettype none
// ============================================================================
// Module   : axil_hold_reg
// Brief    : One-entry valid/ready holding register, emptied by clr.
// Revision : 1.0 - initial release
// ============================================================================
module axil_hold_reg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             in_valid,
    output logic                  in_ready,
    input  wire logic [WIDTH-1:0] in_data,
    input  wire logic             clr,
    output logic                  full,
    output logic [WIDTH-1:0]      data
);
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    // clr is only raised while full, so it never collides with a new accept.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clr) begin
            full_d = 1'b0;
        end
        if (in_valid && !full_q) begin
            full_d = 1'b1;
            data_d = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign in_ready = !full_q;
    assign full     = full_q;
    assign data     = data_q;
endmodule
`default_nettype wire

// File: rtl/axi4_lite_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_reg_bank
// Brief    : AXI4-Lite slave bank of NUM_REGS 32-bit RW/RO registers with
//            per-register write/read strobes. Define AXIL_REG_BANK_SLVERR_EN
//            to answer unmapped accesses with SLVERR instead of OKAY.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_reg_bank
    import axi4_lite_reg_bank_pkg::*;
#(
    parameter int                     ADDR_WIDTH = 8,
    parameter int                     NUM_REGS   = 4,
    parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
    parameter logic [NUM_REGS*32-1:0] RST_VAL    = '0
) (
    input  wire logic                     ACLK,
    input  wire logic                     ARESET,
    axi4_lite_reg_bank_if.slave           s_axil,
    output logic [NUM_REGS*32-1:0]        reg_out,
    input  wire logic [NUM_REGS*32-1:0]   ro_in,
    output logic [NUM_REGS-1:0]           wr_pulse,
    output logic [NUM_REGS-1:0]           rd_pulse
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
`ifdef AXIL_REG_BANK_SLVERR_EN
    localparam resp_t UNMAPPED_RESP = RESP_SLVERR;
`else
    localparam resp_t UNMAPPED_RESP = RESP_OKAY;
`endif

    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_bad_num_regs
        $error("axi4_lite_reg_bank: NUM_REGS must be 1..64");
    end
    if ((2 ** (ADDR_WIDTH - 2)) < NUM_REGS) begin : g_bad_addr_width
        $error("axi4_lite_reg_bank: ADDR_WIDTH too small for NUM_REGS");
    end

    logic                  aw_full, w_full, hold_clr;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [35:0]           w_hold;

    axil_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
        .clk(ACLK), .rst(ARESET),
        .in_valid(s_axil.AWVALID), .in_ready(s_axil.AWREADY), .in_data(s_axil.AWADDR),
        .clr(hold_clr), .full(aw_full), .data(aw_addr)
    );

    axil_hold_reg #(.WIDTH(36)) u_w_hold (
        .clk(ACLK), .rst(ARESET),
        .in_valid(s_axil.WVALID), .in_ready(s_axil.WREADY),
        .in_data({s_axil.WSTRB, s_axil.WDATA}),
        .clr(hold_clr), .full(w_full), .data(w_hold)
    );

    logic [31:0]      w_aw_idx, w_ar_idx;
    logic             w_aw_mapped, w_ar_mapped;
    logic [IDX_W-1:0] w_aw_sel, w_ar_sel;

    assign w_aw_idx    = reg_idx(32'(aw_addr));
    assign w_ar_idx    = reg_idx(32'(s_axil.ARADDR));
    assign w_aw_mapped = w_aw_idx < 32'(NUM_REGS);
    assign w_ar_mapped = w_ar_idx < 32'(NUM_REGS);
    assign w_aw_sel    = w_aw_mapped ? IDX_W'(w_aw_idx) : '0;
    assign w_ar_sel    = w_ar_mapped ? IDX_W'(w_ar_idx) : '0;

    // ---------------- write channel ----------------
    w_state_t            w_state_q, w_state_d;
    resp_t               bresp_q, bresp_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic                commit;

    always_comb begin
        w_state_d  = w_state_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        commit     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_full && w_full) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                    bresp_d   = w_aw_mapped ? RESP_OKAY : UNMAPPED_RESP;
                    if (w_aw_mapped) begin
                        wr_pulse_d[w_aw_sel] = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (s_axil.BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q  <= W_IDLE;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign hold_clr      = commit;
    assign s_axil.BVALID = (w_state_q == W_RESP);
    assign s_axil.BRESP  = bresp_q;
    assign wr_pulse      = wr_pulse_q;

    // RO slots get no storage; their reg_out lanes are tied to zero.
    logic [NUM_REGS*32-1:0] regs_flat;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        if (RO_MASK[gi]) begin : g_ro
            assign regs_flat[32*gi +: 32] = '0;
        end else begin : g_rw
            logic [31:0] reg_q, reg_d;

            always_comb begin
                reg_d = reg_q;
                if (commit && (w_aw_idx == 32'(gi))) begin
                    for (int b = 0; b < STRB_WIDTH; b++) begin
                        if (w_hold[32+b]) begin
                            reg_d[8*b +: 8] = w_hold[8*b +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge ACLK or posedge ARESET) begin
                if (ARESET) begin
                    reg_q <= RST_VAL[32*gi +: 32];
                end else begin
                    reg_q <= reg_d;
                end
            end

            assign regs_flat[32*gi +: 32] = reg_q;
        end
    end

    assign reg_out = regs_flat;

    // ---------------- read channel ----------------
    r_state_t            r_state_q, r_state_d;
    logic [31:0]         rdata_q, rdata_d;
    resp_t               rresp_q, rresp_d;
    logic [NUM_REGS-1:0] rd_pulse_q, rd_pulse_d;

    // Sampling regs_flat before the commit edge returns the pre-write value.
    always_comb begin
        r_state_d  = r_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_pulse_d = '0;
        case (r_state_q)
            R_IDLE: begin
                if (s_axil.ARVALID) begin
                    r_state_d = R_DATA;
                    rresp_d   = w_ar_mapped ? RESP_OKAY : UNMAPPED_RESP;
                    rdata_d   = '0;
                    if (w_ar_mapped) begin
                        rd_pulse_d[w_ar_sel] = 1'b1;
                        rdata_d = RO_MASK[w_ar_sel] ? ro_in[32*w_ar_sel +: 32]
                                                    : regs_flat[32*w_ar_sel +: 32];
                    end
                end
            end
            R_DATA: begin
                if (s_axil.RREADY) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q  <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_pulse_q <= '0;
        end else begin
            r_state_q  <= r_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end

    assign s_axil.ARREADY = (r_state_q == R_IDLE);
    assign s_axil.RVALID  = (r_state_q == R_DATA);
    assign s_axil.RDATA   = rdata_q;
    assign s_axil.RRESP   = rresp_q;
    assign rd_pulse       = rd_pulse_q;
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_reg_bank
// Brief    : Scoreboard bench for axi4_lite_reg_bank with a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_reg_bank;
    localparam int                 AW   = 8;
    localparam int                 NR   = 4;
    localparam logic [NR-1:0]      ROM  = 4'b1000;
    localparam logic [NR*32-1:0]   RSTV = {32'h0, 32'h0, 32'hA5A5_0000, 32'h0};
`ifdef AXIL_REG_BANK_SLVERR_EN
    localparam logic [1:0] UNMAP = 2'b10;
`else
    localparam logic [1:0] UNMAP = 2'b00;
`endif

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    axi4_lite_reg_bank_if #(.ADDR_WIDTH(AW)) bus ();
    logic [NR*32-1:0] reg_out, ro_in;
    logic [NR-1:0]    wr_pulse, rd_pulse;
    logic [31:0]      ro_vals [NR];
    logic [31:0]      model   [NR];

    assign ro_in = {ro_vals[3], ro_vals[2], ro_vals[1], ro_vals[0]};

    axi4_lite_reg_bank #(
        .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(ROM), .RST_VAL(RSTV)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_axil(bus.slave),
        .reg_out(reg_out), .ro_in(ro_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    int total = 0;
    int bad   = 0;
    int b_done = 0;
    int r_done = 0;
    bit force_b_low = 0;
    bit force_r_low = 0;

    logic [1:0]    exp_b [$];
    rsp_t          exp_r [$];
    logic [NR-1:0] exp_wp [$];
    logic [NR-1:0] exp_rp [$];
    rsp_t          mon_e;
    logic [NR-1:0] mon_p;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string why);
        total++;
        bad++;
        $display("FAIL %s: %s", name, why);
    endtask

    function automatic logic [NR*32-1:0] exp_reg_out();
        logic [NR*32-1:0] v;
        logic [NR-1:0]    rom;
        rom = ROM;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = rom[i] ? 32'h0 : model[i];
        return v;
    endfunction

    task automatic reset_model();
        logic [NR*32-1:0] r;
        r = RSTV;
        for (int i = 0; i < NR; i++) model[i] = r[32*i +: 32];
    endtask

    // Reference rules: word index = addr/4, mapped below NR, RO slots ignore data.
    task automatic expect_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int            idx;
        logic [NR-1:0] oh;
        logic [NR-1:0] rom;
        rom = ROM;
        idx = int'(a) / 4;
        if (idx < NR) begin
            oh = '0;
            oh[idx] = 1'b1;
            exp_b.push_back(2'b00);
            exp_wp.push_back(oh);
            if (!rom[idx])
                for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        end else begin
            exp_b.push_back(UNMAP);
        end
    endtask

    task automatic expect_read(input logic [7:0] a);
        int            idx;
        logic [NR-1:0] oh;
        logic [NR-1:0] rom;
        rsp_t          e;
        rom = ROM;
        idx = int'(a) / 4;
        if (idx < NR) begin
            oh = '0;
            oh[idx] = 1'b1;
            e.resp = 2'b00;
            e.data = rom[idx] ? ro_vals[idx] : model[idx];
            exp_rp.push_back(oh);
        end else begin
            e.resp = UNMAP;
            e.data = 32'h0;
        end
        exp_r.push_back(e);
    endtask

    task automatic send_aw(input logic [7:0] a, input int dly);
        int n;
        @(posedge ACLK); #1;
        repeat (dly) begin @(posedge ACLK); #1; end
        bus.AWVALID = 1'b1;
        bus.AWADDR  = a;
        n = 0;
        @(negedge ACLK);
        while (!bus.AWREADY && n < 64) begin @(negedge ACLK); n++; end
        if (!bus.AWREADY) flag("aw_accept", "timeout waiting for AWREADY");
        @(posedge ACLK); #1;
        bus.AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        int n;
        @(posedge ACLK); #1;
        repeat (dly) begin @(posedge ACLK); #1; end
        bus.WVALID = 1'b1;
        bus.WDATA  = d;
        bus.WSTRB  = s;
        n = 0;
        @(negedge ACLK);
        while (!bus.WREADY && n < 64) begin @(negedge ACLK); n++; end
        if (!bus.WREADY) flag("w_accept", "timeout waiting for WREADY");
        @(posedge ACLK); #1;
        bus.WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [7:0] a);
        int n;
        @(posedge ACLK); #1;
        bus.ARVALID = 1'b1;
        bus.ARADDR  = a;
        n = 0;
        @(negedge ACLK);
        while (!bus.ARREADY && n < 64) begin @(negedge ACLK); n++; end
        if (!bus.ARREADY) flag("ar_accept", "timeout waiting for ARREADY");
        @(posedge ACLK); #1;
        bus.ARVALID = 1'b0;
    endtask

    task automatic wait_b(input int tgt);
        int n = 0;
        while (b_done < tgt && n < 300) begin @(negedge ACLK); n++; end
        if (b_done < tgt) flag("b_wait", "timeout waiting for B handshake");
    endtask

    task automatic wait_r(input int tgt);
        int n = 0;
        while (r_done < tgt && n < 300) begin @(negedge ACLK); n++; end
        if (r_done < tgt) flag("r_wait", "timeout waiting for R handshake");
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int skew);
        int tgt;
        tgt = b_done + 1;
        expect_write(a, d, s);
        fork
            send_aw(a, (skew > 0) ? skew : 0);
            send_w(d, s, (skew < 0) ? -skew : 0);
        join
        wait_b(tgt);
        chk("reg_out_after_write", reg_out, exp_reg_out());
    endtask

    task automatic do_read(input logic [7:0] a);
        int tgt;
        tgt = r_done + 1;
        expect_read(a);
        send_ar(a);
        wait_r(tgt);
    endtask

    // Randomised ready generator, updated just after each rising edge.
    initial begin
        bus.BREADY = 1'b0;
        bus.RREADY = 1'b0;
        forever begin
            @(posedge ACLK); #1;
            bus.BREADY = !force_b_low && ($urandom_range(0, 3) != 0);
            bus.RREADY = !force_r_low && ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expectations whenever the DUT presents a completing response.
    initial begin
        forever begin
            @(negedge ACLK);
            if (!ARESET) begin
                if (bus.BVALID && bus.BREADY) begin
                    if (exp_b.size() == 0) flag("bresp", "response with empty scoreboard");
                    else chk("bresp", bus.BRESP, exp_b.pop_front());
                    b_done++;
                end
                if (bus.RVALID && bus.RREADY) begin
                    if (exp_r.size() == 0) flag("rdata", "response with empty scoreboard");
                    else begin
                        mon_e = exp_r.pop_front();
                        chk("rdata", bus.RDATA, mon_e.data);
                        chk("rresp", bus.RRESP, mon_e.resp);
                    end
                    r_done++;
                end
                if (wr_pulse != '0) begin
                    if (exp_wp.size() == 0) flag("wr_pulse", "pulse with empty scoreboard");
                    else begin mon_p = exp_wp.pop_front(); chk("wr_pulse", wr_pulse, mon_p); end
                end
                if (rd_pulse != '0) begin
                    if (exp_rp.size() == 0) flag("rd_pulse", "pulse with empty scoreboard");
                    else begin mon_p = exp_rp.pop_front(); chk("rd_pulse", rd_pulse, mon_p); end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old1;
        logic [7:0]  a;
        int          n;

        bus.AWVALID = 0; bus.AWADDR = '0; bus.WVALID = 0; bus.WDATA = '0; bus.WSTRB = '0;
        bus.ARVALID = 0; bus.ARADDR = '0;
        for (int i = 0; i < NR; i++) ro_vals[i] = 32'h0;
        reset_model();

        // Reset state
        repeat (3) @(negedge ACLK);
        chk("rst_bvalid", bus.BVALID, 1'b0);
        chk("rst_rvalid", bus.RVALID, 1'b0);
        chk("rst_wr_pulse", wr_pulse, '0);
        chk("rst_rd_pulse", rd_pulse, '0);
        chk("rst_reg_out", reg_out, exp_reg_out());
        ARESET = 1'b0;
        do_read(8'h04);

        // W leads AW by three cycles, partial strobes
        do_write(8'h08, 32'hDEAD_BEEF, 4'b0101, 3);
        chk("reg2_strobed", reg_out[95:64], 32'h00AD_00EF);

        // Stalled B channel with a second write queued behind it
        @(negedge ACLK);
        force_b_low = 1;
        @(posedge ACLK); #1;
        expect_write(8'h00, 32'h1111_2222, 4'hF);
        bus.AWVALID = 1; bus.AWADDR = 8'h00; bus.WVALID = 1; bus.WDATA = 32'h1111_2222; bus.WSTRB = 4'hF;
        @(negedge ACLK);
        chk("awready_empty", bus.AWREADY, 1'b1);
        chk("wready_empty", bus.WREADY, 1'b1);
        @(posedge ACLK); #1;
        old1 = model[1];
        expect_write(8'h04, 32'h3333_4444, 4'hF);
        bus.AWADDR = 8'h04; bus.WDATA = 32'h3333_4444;
        @(negedge ACLK);
        chk("bvalid_latency_n", bus.BVALID, 1'b0);
        chk("awready_full", bus.AWREADY, 1'b0);
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("bvalid_latency_n1", bus.BVALID, 1'b1);
        chk("reg0_committed", reg_out[31:0], model[0]);
        chk("awready_refill", bus.AWREADY, 1'b1);
        @(posedge ACLK); #1;
        bus.AWVALID = 0; bus.WVALID = 0;
        repeat (10) @(negedge ACLK);
        chk("bvalid_held", bus.BVALID, 1'b1);
        chk("bresp_held", bus.BRESP, 2'b00);
        chk("reg1_not_committed", reg_out[63:32], old1);
        n = b_done + 2;
        force_b_low = 0;
        wait_b(n);
        chk("reg_out_after_stall", reg_out, exp_reg_out());

        // Read-only slot and unmapped read
        ro_vals[3] = 32'h1234_5678;
        do_write(8'h0C, 32'hCAFE_F00D, 4'hF, 0);
        do_read(8'h0C);
        chk("ro_reg_out_zero", reg_out[127:96], 32'h0);
        do_read(8'h40);
        do_write(8'hF0, 32'hFFFF_FFFF, 4'hF, -2);
        do_write(8'h04, 32'h7777_7777, 4'h0, 1);

        // Random traffic
        for (int k = 0; k < 80; k++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a[7:4] = 4'h0;
            ro_vals[$urandom_range(0, NR - 1)] = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3);
            else
                do_read(a);
        end

        // Asynchronous reset with both responses pending
        @(negedge ACLK);
        force_b_low = 1;
        force_r_low = 1;
        expect_write(8'h08, 32'h0BAD_0BAD, 4'hF);
        expect_read(8'h04);
        fork
            send_aw(8'h08, 0);
            send_w(32'h0BAD_0BAD, 4'hF, 0);
            send_ar(8'h04);
        join
        n = 0;
        while (!(bus.BVALID && bus.RVALID) && n < 50) begin @(negedge ACLK); n++; end
        chk("pre_reset_valids", {bus.BVALID, bus.RVALID}, 2'b11);
        #2;
        ARESET = 1'b1;
        #1;
        chk("async_bvalid", bus.BVALID, 1'b0);
        chk("async_rvalid", bus.RVALID, 1'b0);
        reset_model();
        exp_b.delete(); exp_r.delete(); exp_wp.delete(); exp_rp.delete();
        chk("async_reg_out", reg_out, exp_reg_out());
        force_b_low = 0;
        force_r_low = 0;
        @(negedge ACLK);
        ARESET = 1'b0;
        do_read(8'h04);
        do_read(8'h08);

        repeat (4) @(negedge ACLK);
        chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
        chk("r_queue_empty", 32'(exp_r.size()), 32'd0);
        chk("wp_queue_empty", 32'(exp_wp.size()), 32'd0);
        chk("rp_queue_empty", 32'(exp_rp.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
